// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-flop input synchronizer, mid-bit
// sampling and a valid/ready byte output. Framing errors and overruns are
// reported as single-cycle pulses.
module uart_rx #(
    parameter int CLK_FREQ = 27_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rdata,
    output logic       rvalid,
    input  logic       rready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CPB = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CPB - 1);

    // Fewer than 4 clocks per bit leaves no room for a mid-bit sample point.
    if (CPB < 4) begin : g_cpb_check
        $error("uart_rx: CLK_FREQ/BAUD must be at least 4");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          rx_meta;
    logic          rxs;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          half_hit;
    logic          full_hit;
    logic          shift_en;
    logic          deliver;
    logic          stop_bad;

    assign half_hit = (clk_cnt == HALF_LAST);
    assign full_hit = (clk_cnt == FULL_LAST);

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decisions, all taken on the synchronized line.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_next = START;
                end
            end
            START: begin
                if (half_hit) begin
                    state_next = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (full_hit && (bit_cnt == 3'd7)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (full_hit) begin
                    state_next = rxs ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-state strobes consumed by the datapath, plus the busy flag.
    always_comb begin
        busy     = (state != IDLE);
        shift_en = (state == DATA) && full_hit;
        deliver  = (state == STOP) && full_hit && rxs;
        stop_bad = (state == STOP) && full_hit && !rxs;
    end

    // Bit timing: clk counter restarts at every sample point, bit counter walks 0..7.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt <= '0;
            bit_cnt <= 3'd0;
        end else begin
            case (state)
                START: begin
                    if (half_hit) begin
                        clk_cnt <= '0;
                        bit_cnt <= 3'd0;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (full_hit) begin
                        clk_cnt <= '0;
                        bit_cnt <= bit_cnt + 3'd1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    clk_cnt <= full_hit ? '0 : clk_cnt + 1'b1;
                end
                default: begin
                    clk_cnt <= '0;
                end
            endcase
        end
    end

    // Data shift register, filled LSB first at each data-bit sample point.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= 8'h00;
        end else if (shift_en) begin
            shreg <= {rxs, shreg[7:1]};
        end
    end

    // Output handshake and error pulses; a byte arriving while the previous one
    // is still unaccepted is dropped and flagged, unless it is accepted this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata     <= 8'h00;
            rvalid    <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= deliver && rvalid && !rready;
            if (deliver && (!rvalid || rready)) begin
                rdata  <= shreg;
                rvalid <= 1'b1;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames driven into uart_rx at CPB=10,
// with accepted bytes compared against a queue of the bytes sent.
module tb_uart_rx;

    localparam int CPB = 10;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rdata;
    logic       rvalid;
    logic       rready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int tests_run    = 0;
    int tests_failed = 0;

    int cyc            = 0;
    int last_start_cyc = 0;
    int first_valid    = -1;
    int valid_cycles   = 0;
    int ferr_cnt       = 0;
    int ovr_cnt        = 0;
    int busy_cycles    = 0;
    int both_cnt       = 0;
    logic [7:0] got[$];
    logic [7:0] expq[$];

    uart_rx #(
        .CLK_FREQ(1_000_000),
        .BAUD    (100_000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .rready   (rready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges so latencies can be measured in clocks.
    always @(posedge clk) cyc++;

    // Observe outputs mid-cycle: handshakes, pulses and busy time.
    always @(negedge clk) begin
        if (rvalid) valid_cycles++;
        if (rvalid && first_valid < 0) first_valid = cyc;
        if (rvalid && rready) got.push_back(rdata);
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (frame_err && overrun) both_cnt++;
        if (busy) busy_cycles++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_mon();
        first_valid  = -1;
        valid_cycles = 0;
        ferr_cnt     = 0;
        ovr_cnt      = 0;
        busy_cycles  = 0;
        got.delete();
    endtask

    function automatic logic [31:0] got_at(input int i);
        if (i < got.size()) return {24'h0, got[i]};
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one whole frame; optionally pulse rready for one cycle at tick ready_on.
    task automatic apply_stimulus(input logic [7:0] d, input logic stop, input int ready_on);
        int seg;
        for (int j = 0; j < 10 * CPB; j++) begin
            seg = j / CPB;
            if (j == 0) last_start_cyc = cyc;
            if (seg == 0) rx = 1'b0;
            else if (seg <= 8) rx = d[seg-1];
            else rx = stop;
            if (ready_on >= 0 && j == ready_on) rready = 1'b1;
            if (ready_on >= 0 && j == ready_on + 1) rready = 1'b0;
            tick(1);
        end
        rx = 1'b1;
    endtask

    initial begin
        logic [7:0] da;
        logic [7:0] db;
        logic [7:0] d5;
        int lat;
        int seg;

        rst    = 1'b1;
        rx     = 1'b1;
        rready = 1'b0;
        tick(3);
        check_output("reset_rdata", rdata, 0);
        check_output("reset_rvalid", rvalid, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_frame_err", frame_err, 0);
        check_output("reset_overrun", overrun, 0);
        rst = 1'b0;
        tick(2);

        // Single byte with consumer always ready.
        $display("[TB] single byte 0x48");
        rready = 1'b1;
        clear_mon();
        apply_stimulus(8'h48, 1'b1, -1);
        tick(2 * CPB);
        lat = first_valid - last_start_cyc;
        check_output("t1_latency_97_99", (lat >= 97 && lat <= 99), 1);
        check_output("t1_valid_cycles", valid_cycles, 1);
        check_output("t1_accepts", got.size(), 1);
        check_output("t1_byte", got_at(0), 32'h48);
        check_output("t1_ferr", ferr_cnt, 0);
        check_output("t1_ovr", ovr_cnt, 0);

        // Back-to-back bytes while the consumer stalls.
        da = 8'($urandom_range(0, 255));
        db = 8'($urandom_range(0, 255));
        $display("[TB] overrun with 0x%0h then 0x%0h", da, db);
        rready = 1'b0;
        clear_mon();
        apply_stimulus(da, 1'b1, -1);
        apply_stimulus(db, 1'b1, -1);
        tick(5);
        check_output("t2_rvalid_held", rvalid, 1);
        check_output("t2_rdata_first", rdata, {24'h0, da});
        check_output("t2_ovr_pulses", ovr_cnt, 1);
        check_output("t2_ferr", ferr_cnt, 0);
        rready = 1'b1;
        tick(1);
        check_output("t2_rvalid_drop", rvalid, 0);
        rready = 1'b0;
        check_output("t2_accepts", got.size(), 1);
        check_output("t2_byte", got_at(0), {24'h0, da});

        // Short low glitch must not produce a byte.
        $display("[TB] start-bit glitch");
        clear_mon();
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(3 * CPB);
        check_output("t3_busy_seen", (busy_cycles > 0), 1);
        check_output("t3_busy_idle", busy, 0);
        check_output("t3_no_valid", valid_cycles, 0);
        check_output("t3_ferr", ferr_cnt, 0);

        // Bad stop bit followed by a held-low line, then recovery.
        da = 8'($urandom_range(0, 255));
        $display("[TB] framing error on 0x%0h", da);
        rready = 1'b1;
        clear_mon();
        apply_stimulus(da, 1'b0, -1);
        rx = 1'b0;
        tick(20 * CPB);
        check_output("t4_ferr_pulses", ferr_cnt, 1);
        check_output("t4_no_valid", valid_cycles, 0);
        check_output("t4_busy_break", busy, 1);
        check_output("t4_ovr", ovr_cnt, 0);
        rx = 1'b1;
        tick(CPB);
        check_output("t4_busy_released", busy, 0);
        clear_mon();
        apply_stimulus(8'h0F, 1'b1, -1);
        tick(CPB);
        check_output("t4_accepts", got.size(), 1);
        check_output("t4_byte", got_at(0), 32'h0F);
        check_output("t4_ferr_after", ferr_cnt, 0);

        // Reset in the middle of bit 4 of a frame.
        d5 = 8'($urandom_range(0, 255));
        $display("[TB] reset mid-frame of 0x%0h", d5);
        clear_mon();
        for (int j = 0; j < 5 * CPB + CPB / 2; j++) begin
            seg = j / CPB;
            rx = (seg == 0) ? 1'b0 : d5[seg-1];
            tick(1);
        end
        rst = 1'b1;
        rx  = 1'b1;
        tick(1);
        check_output("t5_rst_rdata", rdata, 0);
        check_output("t5_rst_rvalid", rvalid, 0);
        check_output("t5_rst_busy", busy, 0);
        check_output("t5_rst_ferr", frame_err, 0);
        check_output("t5_rst_ovr", overrun, 0);
        rst = 1'b0;
        tick(15 * CPB);
        check_output("t5_no_valid", valid_cycles, 0);
        d5 = 8'($urandom_range(0, 255));
        clear_mon();
        apply_stimulus(d5, 1'b1, -1);
        tick(CPB);
        check_output("t5_accepts", got.size(), 1);
        check_output("t5_byte", got_at(0), {24'h0, d5});

        // Acceptance in the same cycle as the next delivery avoids an overrun.
        da = 8'($urandom_range(0, 255));
        db = 8'($urandom_range(0, 255));
        $display("[TB] accept-on-delivery 0x%0h then 0x%0h", da, db);
        rready = 1'b0;
        clear_mon();
        apply_stimulus(da, 1'b1, -1);
        tick(5);
        check_output("t6_first_valid", rvalid, 1);
        check_output("t6_first_rdata", rdata, {24'h0, da});
        apply_stimulus(db, 1'b1, 97);
        check_output("t6_rvalid_stays", rvalid, 1);
        check_output("t6_rdata_second", rdata, {24'h0, db});
        check_output("t6_no_ovr", ovr_cnt, 0);
        check_output("t6_accepts", got.size(), 1);
        check_output("t6_accepted_first", got_at(0), {24'h0, da});
        rready = 1'b1;
        tick(1);
        rready = 1'b0;
        check_output("t6_drained", rvalid, 0);

        // Random stream with idle gaps of random length; all bytes must arrive in order.
        $display("[TB] random stream");
        rready = 1'b1;
        clear_mon();
        expq.delete();
        for (int n = 0; n < 8; n++) begin
            da = 8'($urandom_range(0, 255));
            expq.push_back(da);
            apply_stimulus(da, 1'b1, -1);
            tick($urandom_range(0, 2 * CPB));
        end
        tick(CPB);
        check_output("rand_count", got.size(), expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            check_output($sformatf("rand_byte_%0d", i), got_at(i), {24'h0, expq[i]});
        end
        check_output("rand_ferr", ferr_cnt, 0);
        check_output("rand_ovr", ovr_cnt, 0);

        check_output("never_both_pulses", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
